// File: rtl/pb_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
package pb_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1024;
  localparam int unsigned LONG_CYCLES_DEF     = 65536;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } pb_state_e;

endpackage

// File: rtl/pb_debounce_if.sv
// Button-side bundle: raw active-low level in, debounced level and strobes out.
interface pb_debounce_if;

  logic PB;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output PB,
    input  pressed,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  PB,
    output pressed,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );

endinterface

// File: rtl/pb_sync2.sv
// Two-flop synchronizer; presets to 1 (button released) on reset.
module pb_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pb_debounce.sv
// Push-button debouncer: synchronizes PB, accepts press/release after a stable
// window, and emits press, release and one-shot long-press strobes.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  pb_debounce_if.slave io_pb
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              w_pb_s;
  pb_state_e         r_state;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_long_done;
  logic              r_pressed;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_long_pulse;

  pb_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (io_pb.PB),
    .o_q (w_pb_s)
  );

  // Debounce FSM; strobes default low so each lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= IDLE;
      r_deb_cnt       <= '0;
      r_hold_cnt      <= '0;
      r_long_done     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_pb_s) begin
            r_state   <= PRESS_WAIT;
            r_deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (w_pb_s) begin
            r_state <= IDLE;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state       <= PRESSED;
            r_press_pulse <= 1'b1;
            r_pressed     <= 1'b1;
            r_hold_cnt    <= '0;
            r_long_done   <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        PRESSED: begin
          // Hold counter saturates; long_done keeps the long strobe one-shot.
          if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end else if (!r_long_done) begin
            r_long_pulse <= 1'b1;
            r_long_done  <= 1'b1;
          end
          if (w_pb_s) begin
            r_state   <= RELEASE_WAIT;
            r_deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (!w_pb_s) begin
            r_state <= PRESSED;
          end else if (r_deb_cnt == DEB_LAST) begin
            r_state         <= IDLE;
            r_release_pulse <= 1'b1;
            r_pressed       <= 1'b0;
          end else begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_pb.pressed       = r_pressed;
  assign io_pb.press_pulse   = r_press_pulse;
  assign io_pb.release_pulse = r_release_pulse;
  assign io_pb.long_pulse    = r_long_pulse;

endmodule

// File: tb/tb_pb_debounce.sv
// Scoreboard bench for pb_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_pb_debounce;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 10;
  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  q[$];

  pb_debounce_if bus ();

  pb_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_pb (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void expect_ev(input int kind, input int at_cyc);
    ev_t e;
    e.kind = kind;
    e.cyc  = at_cyc;
    q.push_back(e);
  endfunction

  // Strobes are sampled mid-cycle and matched in order against the scoreboard.
  always @(negedge clk) begin : mon
    logic [2:0] p;
    ev_t        e;
    string      nm [3];
    nm = '{"press", "release", "long"};
    p  = {bus.long_pulse, bus.release_pulse, bus.press_pulse};
    if (p[K_PRESS] && p[K_RELEASE]) chk("press_release_overlap", 1, 0);
    for (int k = 0; k < 3; k++) begin
      if (p[k]) begin
        if (q.size() == 0) begin
          chk({"unexpected_", nm[k]}, 1, 0);
        end else begin
          e = q.pop_front();
          chk({nm[k], "_kind"}, k, e.kind);
          chk({nm[k], "_cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  initial begin : stim
    int c;
    bus.PB = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pressed", int'(bus.pressed), 0);
    chk("rst_press_pulse", int'(bus.press_pulse), 0);
    chk("rst_release_pulse", int'(bus.release_pulse), 0);
    chk("rst_long_pulse", int'(bus.long_pulse), 0);

    // Clean press held 40 cycles, then clean release.
    c = cyc;
    bus.PB = 1'b0;
    expect_ev(K_PRESS, c + 7);
    expect_ev(K_LONG, c + 17);
    repeat (6) @(negedge clk);
    chk("clean_not_yet_pressed", int'(bus.pressed), 0);
    @(negedge clk);
    chk("clean_pressed", int'(bus.pressed), 1);
    repeat (33) @(negedge clk);
    chk("hold_saturated", int'(dut.r_hold_cnt), LNG - 1);
    c = cyc;
    bus.PB = 1'b1;
    expect_ev(K_RELEASE, c + 7);
    repeat (6) @(negedge clk);
    chk("release_not_yet", int'(bus.pressed), 1);
    repeat (6) @(negedge clk);
    chk("clean_released", int'(bus.pressed), 0);

    // Press bounce, then a release bounce after the long strobe.
    bus.PB = 1'b0;
    repeat (3) @(negedge clk);
    bus.PB = 1'b1;
    repeat (2) @(negedge clk);
    c = cyc;
    bus.PB = 1'b0;
    expect_ev(K_PRESS, c + 7);
    expect_ev(K_LONG, c + 17);
    repeat (25) @(negedge clk);
    bus.PB = 1'b1;
    repeat (2) @(negedge clk);
    bus.PB = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rel_bounce_pressed", int'(bus.pressed), 1);
    end
    repeat (5) @(negedge clk);
    c = cyc;
    bus.PB = 1'b1;
    expect_ev(K_RELEASE, c + 7);
    repeat (12) @(negedge clk);
    chk("bounce_released", int'(bus.pressed), 0);

    // Short press: no long strobe.
    c = cyc;
    bus.PB = 1'b0;
    expect_ev(K_PRESS, c + 7);
    repeat (8) @(negedge clk);
    c = cyc;
    bus.PB = 1'b1;
    expect_ev(K_RELEASE, c + 7);
    repeat (12) @(negedge clk);
    chk("short_released", int'(bus.pressed), 0);

    // Reset mid-press: no release strobe, held button re-debounced.
    c = cyc;
    bus.PB = 1'b0;
    expect_ev(K_PRESS, c + 7);
    repeat (10) @(negedge clk);
    chk("pre_rst_pressed", int'(bus.pressed), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_pressed", int'(bus.pressed), 0);
    chk("rst_async_press_pulse", int'(bus.press_pulse), 0);
    chk("rst_async_release_pulse", int'(bus.release_pulse), 0);
    chk("rst_async_long_pulse", int'(bus.long_pulse), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c = cyc;
    expect_ev(K_PRESS, c + 7);
    repeat (6) @(negedge clk);
    chk("post_rst_not_yet", int'(bus.pressed), 0);
    repeat (6) @(negedge clk);
    chk("post_rst_pressed", int'(bus.pressed), 1);
    c = cyc;
    bus.PB = 1'b1;
    expect_ev(K_RELEASE, c + 7);
    repeat (12) @(negedge clk);

    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
